// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared opcodes, line map and FSM states for the LCD write-bus decoder
package lcd_bus_pkg;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FSET = 8'h20;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN = 7'd16;
  typedef enum logic [1:0] {IDLE, CLEAR, BUSY} state_t;
endpackage

// File: rtl/lcd_bus_decoder_if.sv
// lcd_bus_decoder_if: LCD write bus plus the decoder's readback/status signals
interface lcd_bus_decoder_if;
  logic lcd_e;
  logic lcd_rs;
  logic lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic busy;
  logic disp_on;
  logic wr_strobe;
  logic cmd_strobe;
  logic [7:0] cmd_code;
  logic proto_err;
  modport master (
    output lcd_e, lcd_rs, lcd_rw, lcd_data, rd_addr,
    input rd_char, cursor, busy, disp_on, wr_strobe, cmd_strobe, cmd_code, proto_err
  );
  modport slave (
    input lcd_e, lcd_rs, lcd_rw, lcd_data, rd_addr,
    output rd_char, cursor, busy, disp_on, wr_strobe, cmd_strobe, cmd_code, proto_err
  );
endinterface

// File: rtl/lcd_ddram_buf.sv
// lcd_ddram_buf: 32x8 DDRAM image, reset to spaces, one write port, registered read
module lcd_ddram_buf
  import lcd_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] mem_q [32];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= SPACE_CHAR;
      rdata_o <= SPACE_CHAR;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
    end
  end
endmodule

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: far-end HD44780 write-bus model with 2x16 DDRAM image, busy emulation and error flag
module lcd_bus_decoder
  import lcd_bus_pkg::*;
#(
  parameter int BUSY_CYCLES = 40,
  parameter int CLEAR_BUSY_CYCLES = 1640
) (
  input logic clk,
  input logic rst,
  lcd_bus_decoder_if.slave bus
);
  localparam int CW = $clog2(CLEAR_BUSY_CYCLES + 1);
  localparam logic [CW-1:0] N_BUSY = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] N_HOME = CW'(CLEAR_BUSY_CYCLES);
  localparam logic [CW-1:0] N_TAIL = CW'(CLEAR_BUSY_CYCLES - 32);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] cur_q, cur_d, clr_q, clr_d;
  logic [7:0] code_q, code_d, dat_q;
  logic inc_q, inc_d, disp_q, disp_d, err_q, err_d;
  logic wrs_q, wrs_d, cms_q, cms_d;
  logic e_q, rs_q, rw_q;
  logic busy, commit, clearing;
  logic [6:0] off1, off2;
  assign clearing = state_q == CLEAR;
  assign busy = cnt_q != '0 || clearing;
  // a transaction lands on the first low cycle after enable was high; reads never commit
  assign commit = e_q && !bus.lcd_e && !rw_q;
  assign off1 = dat_q[6:0] - LINE1_BASE;
  assign off2 = dat_q[6:0] - LINE2_BASE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    clr_d = clr_q;
    inc_d = inc_q;
    disp_d = disp_q;
    err_d = err_q;
    code_d = code_q;
    wrs_d = 1'b0;
    cms_d = 1'b0;
    if (clearing) begin
      clr_d = clr_q + 5'd1;
      if (clr_q == 5'd31) begin
        state_d = N_TAIL == '0 ? IDLE : BUSY;
        cnt_d = N_TAIL;
      end
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = IDLE;
    end
    if (commit && busy) begin
      err_d = 1'b1;
    end else if (commit && rs_q) begin
      wrs_d = 1'b1;
      cur_d = cur_q + (inc_q ? 5'd1 : 5'd31);
      state_d = BUSY;
      cnt_d = N_BUSY;
    end else if (commit) begin
      cms_d = 1'b1;
      code_d = dat_q;
      state_d = BUSY;
      cnt_d = N_BUSY;
      if (dat_q >= CMD_DDRAM) begin
        if (off1 < LINE_LEN) cur_d = off1[4:0];
        else if (off2 < LINE_LEN) cur_d = off2[4:0] + LINE_LEN[4:0];
        else err_d = 1'b1;
      end else if (dat_q >= CMD_SHIFT && dat_q < CMD_FSET) begin
        if (!dat_q[3]) cur_d = cur_q + (dat_q[2] ? 5'd1 : 5'd31);
      end else if (dat_q >= CMD_DISP && dat_q < CMD_SHIFT) begin
        disp_d = dat_q[2];
      end else if (dat_q >= CMD_ENTRY && dat_q < CMD_DISP) begin
        inc_d = dat_q[1];
      end else if (dat_q >= CMD_HOME && dat_q < CMD_ENTRY) begin
        cur_d = '0;
        cnt_d = N_HOME;
      end else if (dat_q == CMD_CLEAR) begin
        cur_d = '0;
        inc_d = 1'b1;
        clr_d = '0;
        cnt_d = '0;
        state_d = CLEAR;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_q <= '0;
      clr_q <= '0;
      inc_q <= 1'b1;
      disp_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
      wrs_q <= 1'b0;
      cms_q <= 1'b0;
      e_q <= 1'b0;
      rs_q <= 1'b0;
      rw_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      clr_q <= clr_d;
      inc_q <= inc_d;
      disp_q <= disp_d;
      err_q <= err_d;
      code_q <= code_d;
      wrs_q <= wrs_d;
      cms_q <= cms_d;
      e_q <= bus.lcd_e;
      if (bus.lcd_e) begin
        rs_q <= bus.lcd_rs;
        rw_q <= bus.lcd_rw;
        dat_q <= bus.lcd_data;
      end
    end
  end
  lcd_ddram_buf u_buf (
    .clk(clk),
    .rst(rst),
    .we_i(clearing || (commit && !busy && rs_q)),
    .waddr_i(clearing ? clr_q : cur_q),
    .wdata_i(clearing ? SPACE_CHAR : dat_q),
    .raddr_i(bus.rd_addr),
    .rdata_o(bus.rd_char)
  );
  assign bus.cursor = cur_q;
  assign bus.busy = busy;
  assign bus.disp_on = disp_q;
  assign bus.wr_strobe = wrs_q;
  assign bus.cmd_strobe = cms_q;
  assign bus.cmd_code = code_q;
  assign bus.proto_err = err_q;
endmodule

// File: doc/lcd_bus_decoder.md
Name: lcd_bus_decoder

Overview:
- Synthesizable far-end model of the character-LCD write bus (lcd_e, lcd_rs, lcd_rw, lcd_data) driven by the calculator top.
- Decodes HD44780-style instruction and data writes into a 2x16 character buffer (DDRAM image).
- Tracks cursor and display state, emulates the busy window, and flags protocol violations.
- Sits beside the calculator in system benches and on-board self-check builds, so displayed text can be read back through a simple port.

Parameters:
- BUSY_CYCLES, 40, clk cycles busy after a normal instruction or data write.
- CLEAR_BUSY_CYCLES, 1640, clk cycles busy after clear or return-home. Must be >= 32.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- lcd_e  input  1  LCD enable strobe.
- lcd_rs  input  1  register select: 0 = instruction, 1 = data.
- lcd_rw  input  1  1 = read; reads are ignored.
- lcd_data  input  8  LCD data bus.
- rd_addr  input  5  buffer read index: 0-15 = line 1, 16-31 = line 2.
- rd_char  output  8  buffer[rd_addr], registered, 1-cycle latency.
- cursor  output  5  current buffer index.
- busy  output  1  busy counter non-zero, or clear sequence running.
- disp_on  output  1  D bit from display-control instruction.
- wr_strobe  output  1  1-cycle pulse on each accepted data write.
- cmd_strobe  output  1  1-cycle pulse on each accepted instruction.
- cmd_code  output  8  last accepted instruction byte.
- proto_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - all buffer entries to 0x20; cursor 0; increment mode 1;
  - disp_on 0, busy 0, busy count 0, cmd_code 0x00, proto_err 0; strobes 0;
  - FSM to IDLE.
- Reset during CLEAR or BUSY aborts immediately to the reset state.
- Sampling:
  - lcd_rs, lcd_rw and lcd_data are captured every cycle lcd_e=1.
  - A transaction commits in the first cycle lcd_e=0 after lcd_e=1 (falling edge), using the last captured values.
  - An lcd_e high of a single cycle is valid.
- lcd_rw=1 commit: no state change, no strobe.
- Commit while busy=1: transaction discarded, proto_err set.
  - A commit in the same cycle the count reaches 0 is accepted, because busy is evaluated on the registered count.
- FSM states: IDLE, CLEAR, BUSY.
  - IDLE: accepts commits.
  - CLEAR: writes 0x20 to index 0..31, one per cycle (32 cycles), then goes to BUSY with count CLEAR_BUSY_CYCLES-32.
  - BUSY: decrements count each cycle; returns to IDLE at 0.
- Instruction decode (rs=0), by highest set bit; each accepted instruction sets cmd_code and pulses cmd_strobe:
  - 0x01 clear: cursor 0, increment mode 1, enter CLEAR.
  - 0x02-0x03 home: cursor 0, busy CLEAR_BUSY_CYCLES.
  - 0x04-0x07 entry mode: increment mode = bit1; S bit ignored.
  - 0x08-0x0F display control: disp_on = bit2.
  - 0x10-0x1F shift: bit3=0 moves cursor one step (bit2=1 right, else left); bit3=1 (display shift) ignored.
  - 0x20-0x7F function set / CGRAM address: accepted, no effect.
  - 0x80-0xFF set DDRAM address: address 0x00-0x0F maps to 0-15; 0x40-0x4F maps to 16-31. Any other address sets proto_err and leaves cursor unchanged.
  - Every instruction except clear and home loads BUSY_CYCLES.
- Data write (rs=1):
  - buffer[cursor] = lcd_data; pulse wr_strobe; load BUSY_CYCLES.
  - cursor moves +1 or -1 modulo 32: 15->16, 31->0, 0->31 on decrement.
- Buffer write and rd_addr read of the same index in one cycle: rd_char shows the old value that cycle, the new value the next cycle.

Decomposition:
- Package lcd_bus_pkg holds:
  - instruction opcode/mask constants;
  - SPACE_CHAR = 0x20;
  - line base addresses 0x00 and 0x40, LINE_LEN = 16;
  - FSM state enum {IDLE, CLEAR, BUSY}.
- Sub-module lcd_ddram_buf: 32x8 register file with async reset to 0x20, one write port, registered read port. Decoder, FSM and busy counter stay in the top.

Test Plan:
- Reset release, then pulse 0x38, 0x0C, 0x06, 0x01 with gaps longer than busy -> disp_on=1; busy high for CLEAR_BUSY_CYCLES; all rd_char = 0x20; cmd_code=0x01.
- Data writes "4","+","5" (0x34, 0x2B, 0x35) -> buffer[0..2] = 0x34, 0x2B, 0x35; cursor=3; three wr_strobe pulses.
- Instruction 0xC0, then data 0x39 -> buffer[16]=0x39, cursor=17. Cursor at 31 plus one data write -> cursor=0. Entry 0x04 at cursor 0 plus one write -> cursor=31.
- Second write issued 10 cycles after the first -> discarded, buffer unchanged, proto_err=1 until reset.
- rst=0 at cycle 5 of CLEAR -> immediate reset state, busy=0; after release, buffer all 0x20.
- Instruction 0x90 (address 0x10) -> proto_err=1, cursor unchanged; cmd_strobe still pulses.
